// File: rtl/mux_pkg.sv
// Shared definitions for the parameterised stream multiplexer.
//   state_e : arbitration state encoding (idle = 0, locked = 1)
//   clog2   : ceiling log2, never less than 1, used to size select/grant ports
package mux_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StLock = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search.
//   req   : per-channel request vector
//   ptr   : channel index the search starts from (must be < NCH)
//   found : at least one request is set
//   idx   : first requesting channel at or above ptr, wrapping NCH-1 -> 0
module rr_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned SW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic           found,
  output logic [SW-1:0]  idx
);

  int unsigned c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      c = 32'(ptr) + i;
      if (c >= NCH) begin
        c = c - NCH;
      end
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = SW'(c);
      end
    end
  end

endmodule

// File: rtl/param_stream_mux.sv
// Packet-locked stream multiplexer: selects one of NCH valid/ready input
// streams (fixed index or round-robin) and forwards it, beat by beat, through
// a single output register until the channel's last beat has been accepted.
//   clk, rst_n         : clock, asynchronous active-low reset
//   mode, sel          : 0 = fixed channel sel, 1 = round-robin
//   in_valid/data/last : per-channel input streams, channel k in data[k*W +: W]
//   in_ready           : per-channel ready, only the locked channel can be ready
//   out_valid/data/last, out_ready : registered output stream
//   grant, busy        : locked channel index, lock held
module param_stream_mux
  import mux_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned SW  = clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_last,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [SW-1:0]    grant,
  output logic             busy
);

  state_e          state_q, state_d;
  logic [SW-1:0]   grant_q, grant_d;
  logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [W-1:0]    out_data_q, out_data_d;

  logic            rr_found;
  logic [SW-1:0]   rr_idx;
  logic            load_ok;
  logic            fix_hit;
  logic            gnt_valid;
  logic            gnt_last;
  logic [W-1:0]    gnt_data;
  logic            accept;

  rr_arbiter #(
    .NCH (NCH),
    .SW  (SW)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Output register may take a new beat when empty or draining this cycle.
  assign load_ok = !out_valid_q || out_ready;

  // Channel decode by comparison rather than indexing, so a sel value beyond
  // NCH-1 simply matches nothing.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    fix_hit   = 1'b0;
    in_ready  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (grant_q == SW'(k)) begin
        gnt_valid = in_valid[k];
        gnt_last  = in_last[k];
        gnt_data  = in_data[k*W +: W];
        if (state_q == StLock) begin
          in_ready[k] = load_ok;
        end
      end
      if (sel == SW'(k) && in_valid[k]) begin
        fix_hit = 1'b1;
      end
    end
  end

  assign accept = (state_q == StLock) && gnt_valid && load_ok;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (mode) begin
          if (rr_found) begin
            grant_d = rr_idx;
            state_d = StLock;
          end
        end else if (fix_hit) begin
          grant_d = sel;
          state_d = StLock;
        end
      end
      StLock: begin
        if (accept && gnt_last) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == SW'(NCH - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_last_d  = gnt_last;
      out_data_d  = gnt_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign grant     = grant_q;
  assign busy      = (state_q == StLock);

endmodule

// File: tb/tb_param_stream_mux.sv
// Directed bench for param_stream_mux: a 4-channel instance for the main
// scenarios and a 3-channel instance for the out-of-range select case.
module tb_param_stream_mux;

  logic        clk;
  logic        rst_n;

  // 4-channel, 8-bit instance
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  grant;
  logic        busy;

  // 3-channel, 8-bit instance
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [2:0]  b_in_valid;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_last;
  logic [2:0]  b_in_ready;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic        b_out_last;
  logic        b_out_ready;
  logic [1:0]  b_grant;
  logic        b_busy;

  int n_vec;
  int n_err;

  param_stream_mux #(.NCH(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  param_stream_mux #(.NCH(3), .W(8)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (b_mode),
    .sel       (b_sel),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_last   (b_in_last),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_last  (b_out_last),
    .out_ready (b_out_ready),
    .grant     (b_grant),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [7:0] d, input logic l);
    in_valid[k]        = v;
    in_data[k*8 +: 8]  = d;
    in_last[k]         = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    mode        = 1'b0;
    sel         = '0;
    in_valid    = '0;
    in_data     = '0;
    in_last     = '0;
    out_ready   = 1'b1;
    b_mode      = 1'b0;
    b_sel       = '0;
    b_in_valid  = '0;
    b_in_data   = '0;
    b_in_last   = '0;
    b_out_ready = 1'b1;

    // Reset state
    #3;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_data", 32'(out_data), 0);
    check("rst busy", 32'(busy), 0);
    check("rst grant", 32'(grant), 0);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst b_busy", 32'(b_busy), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("idle in_ready", 32'(in_ready), 0);

    // Fixed mode, 3-beat packet on ch2
    mode = 1'b0;
    sel  = 2'd2;
    drive(2, 1'b1, 8'hA1, 1'b0);
    step();
    check("fix busy", 32'(busy), 1);
    check("fix grant", 32'(grant), 2);
    check("fix in_ready", 32'(in_ready), 32'h4);
    check("fix out_valid pre", 32'(out_valid), 0);
    step();
    check("fix A1 valid", 32'(out_valid), 1);
    check("fix A1 data", 32'(out_data), 32'hA1);
    check("fix A1 last", 32'(out_last), 0);
    drive(2, 1'b1, 8'hA2, 1'b0);
    step();
    check("fix A2 data", 32'(out_data), 32'hA2);
    drive(2, 1'b1, 8'hA3, 1'b1);
    step();
    check("fix A3 data", 32'(out_data), 32'hA3);
    check("fix A3 last", 32'(out_last), 1);
    check("fix A3 busy", 32'(busy), 0);
    check("fix A3 in_ready", 32'(in_ready), 0);
    drive(2, 1'b0, 8'h00, 1'b0);
    step();
    check("fix drain valid", 32'(out_valid), 0);
    check("fix drain busy", 32'(busy), 0);

    // Round-robin over four single-beat packets, pointer restarts at 0
    rst_n = 1'b0;
    #4 rst_n = 1'b1;
    mode = 1'b1;
    for (int k = 0; k < 4; k++) drive(k, 1'b1, 8'h10 + 8'(k), 1'b1);
    for (int i = 0; i < 5; i++) begin
      int e;
      e = i % 4;
      step();
      check("rr grant", 32'(grant), 32'(e));
      check("rr busy", 32'(busy), 1);
      check("rr in_ready", 32'(in_ready), 32'(1) << e);
      step();
      check("rr data", 32'(out_data), 32'h10 + 32'(e));
      check("rr last", 32'(out_last), 1);
      check("rr release", 32'(busy), 0);
    end
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'h00, 1'b0);

    // Lock held through a gap; next grant searched from ch2
    drive(1, 1'b1, 8'h21, 1'b0);
    step();
    check("lk grant1", 32'(grant), 1);
    drive(0, 1'b1, 8'h01, 1'b1);
    drive(3, 1'b1, 8'h31, 1'b1);
    step();
    check("lk data21", 32'(out_data), 32'h21);
    check("lk busy", 32'(busy), 1);
    drive(1, 1'b0, 8'h21, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("lk gap grant", 32'(grant), 1);
      check("lk gap busy", 32'(busy), 1);
      check("lk gap valid", 32'(out_valid), 0);
    end
    drive(1, 1'b1, 8'h22, 1'b1);
    step();
    check("lk data22", 32'(out_data), 32'h22);
    check("lk last22", 32'(out_last), 1);
    check("lk release", 32'(busy), 0);
    drive(1, 1'b0, 8'h00, 1'b0);
    step();
    check("lk next grant", 32'(grant), 3);
    check("lk next busy", 32'(busy), 1);
    step();
    check("lk data31", 32'(out_data), 32'h31);
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(3, 1'b0, 8'h00, 1'b0);

    // Backpressure: 5 stalled cycles, no loss or duplication
    mode = 1'b0;
    sel  = 2'd0;
    drive(0, 1'b1, 8'h51, 1'b0);
    step();
    check("bp grant", 32'(grant), 0);
    step();
    check("bp data51", 32'(out_data), 32'h51);
    out_ready = 1'b0;
    drive(0, 1'b1, 8'h52, 1'b0);
    #1;
    check("bp stall ready", 32'(in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp hold valid", 32'(out_valid), 1);
      check("bp hold data", 32'(out_data), 32'h51);
      check("bp hold ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp resume ready", 32'(in_ready), 1);
    step();
    check("bp data52", 32'(out_data), 32'h52);
    drive(0, 1'b1, 8'h53, 1'b0);
    step();
    check("bp data53", 32'(out_data), 32'h53);
    drive(0, 1'b1, 8'h54, 1'b1);
    step();
    check("bp data54", 32'(out_data), 32'h54);
    check("bp last54", 32'(out_last), 1);
    drive(0, 1'b0, 8'h00, 1'b0);
    step();
    check("bp drain", 32'(out_valid), 0);

    // Reset during 2nd beat of a packet
    sel = 2'd2;
    drive(2, 1'b1, 8'h61, 1'b0);
    step();
    check("mr grant", 32'(grant), 2);
    step();
    check("mr data61", 32'(out_data), 32'h61);
    drive(2, 1'b1, 8'h62, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mr out_valid", 32'(out_valid), 0);
    check("mr out_data", 32'(out_data), 0);
    check("mr out_last", 32'(out_last), 0);
    check("mr busy", 32'(busy), 0);
    check("mr grant0", 32'(grant), 0);
    check("mr in_ready", 32'(in_ready), 0);
    step();
    check("mr held busy", 32'(busy), 0);
    drive(2, 1'b1, 8'h91, 1'b1);
    drive(0, 1'b1, 8'h71, 1'b1);
    mode  = 1'b1;
    rst_n = 1'b1;
    step();
    check("mr regrant", 32'(grant), 0);
    check("mr rebusy", 32'(busy), 1);
    step();
    check("mr data71", 32'(out_data), 32'h71);
    check("mr last71", 32'(out_last), 1);
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'h00, 1'b0);

    // 3-channel instance: sel out of range never grants
    b_mode     = 1'b0;
    b_sel      = 2'd3;
    b_in_valid = 3'b111;
    b_in_data  = 24'hC2_C1_C0;
    b_in_last  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("oor busy", 32'(b_busy), 0);
      check("oor in_ready", 32'(b_in_ready), 0);
      check("oor out_valid", 32'(b_out_valid), 0);
    end
    b_sel = 2'd2;
    step();
    check("oor sel2 grant", 32'(b_grant), 2);
    check("oor sel2 busy", 32'(b_busy), 1);
    check("oor sel2 ready", 32'(b_in_ready), 32'h4);
    step();
    check("oor sel2 data", 32'(b_out_data), 32'hC2);
    b_in_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
